// File: rtl/fp32_pkg.sv
// ============================================================================
// Module  : fp32_pkg
// Brief   : binary32 field constants and accumulator FSM state encoding.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fp32_pkg;

    localparam int          FP_BIAS     = 127;
    localparam int          FP_EXP_MAX  = 255;
    localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

    localparam int          FP_SIGN_BIT = 31;
    localparam int          FP_EXP_MSB  = 30;
    localparam int          FP_EXP_LSB  = 23;
    localparam int          FP_FRAC_MSB = 22;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_ADD   = 2'd2,
        ST_NORM  = 2'd3
    } acc_state_t;

endpackage

`default_nettype wire

// File: rtl/float_accumulator_if.sv
// ============================================================================
// Module  : float_accumulator_if
// Brief   : Term input handshake and batch result bus of the accumulator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface float_accumulator_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_last;
    logic             in_ready;
    logic [31:0]      acc_out;
    logic             out_valid;
    logic [CNT_W-1:0] term_count;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, acc_out, out_valid, term_count
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, acc_out, out_valid, term_count
    );
endinterface

`default_nettype wire

// File: rtl/fp_lzc24.sv
// ============================================================================
// Module  : fp_lzc24
// Brief   : Combinational 24-bit leading-zero counter (24 for an all-zero input).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_lzc24 (
    input  wire logic [23:0] i_data,
    output logic      [4:0]  o_count
);
    // Ascending scan: the highest set bit is visited last and wins.
    always_comb begin
        o_count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (i_data[i]) o_count = 5'(23 - i);
        end
    end
endmodule

`default_nettype wire

// File: rtl/float_accumulator.sv
// ============================================================================
// Module  : float_accumulator
// Brief   : Four-state binary32 accumulator (truncating, flush-to-zero).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module float_accumulator
    import fp32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear,
    output logic                  busy,
    float_accumulator_if.slave    bus
);
    acc_state_t       r_state;
    logic [31:0]      r_acc, r_a_raw, r_b_raw, r_special_val, r_acc_out;
    logic             r_last, r_sa, r_sb, r_special, r_out_valid, r_in_ready, r_busy;
    logic [CNT_W-1:0] r_cnt, r_term_count;
    logic [7:0]       r_exp;
    logic [23:0]      r_ma, r_mb;
    logic [24:0]      r_sum;

    // ALIGN: unpack, order by magnitude, align the smaller significand
    logic [7:0]  w_ea, w_eb, w_e_big, w_e_small, w_diff;
    logic [23:0] w_ma, w_mb, w_m_big, w_m_small;
    logic [30:0] w_mag_a, w_mag_b;
    logic        w_swap, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic [4:0]  w_shamt;

    assign w_ea    = r_a_raw[FP_EXP_MSB:FP_EXP_LSB];
    assign w_eb    = r_b_raw[FP_EXP_MSB:FP_EXP_LSB];
    assign w_ma    = (w_ea == 8'd0) ? 24'd0 : {1'b1, r_a_raw[FP_FRAC_MSB:0]};
    assign w_mb    = (w_eb == 8'd0) ? 24'd0 : {1'b1, r_b_raw[FP_FRAC_MSB:0]};
    assign w_mag_a = (w_ea == 8'd0) ? 31'd0 : r_a_raw[FP_EXP_MSB:0];
    assign w_mag_b = (w_eb == 8'd0) ? 31'd0 : r_b_raw[FP_EXP_MSB:0];
    assign w_swap  = w_mag_b > w_mag_a;

    assign w_a_nan = (w_ea == 8'(FP_EXP_MAX)) && (r_a_raw[FP_FRAC_MSB:0] != 23'd0);
    assign w_b_nan = (w_eb == 8'(FP_EXP_MAX)) && (r_b_raw[FP_FRAC_MSB:0] != 23'd0);
    assign w_a_inf = (w_ea == 8'(FP_EXP_MAX)) && (r_a_raw[FP_FRAC_MSB:0] == 23'd0);
    assign w_b_inf = (w_eb == 8'(FP_EXP_MAX)) && (r_b_raw[FP_FRAC_MSB:0] == 23'd0);

    assign w_e_big   = w_swap ? w_eb : w_ea;
    assign w_e_small = w_swap ? w_ea : w_eb;
    assign w_m_big   = w_swap ? w_mb : w_ma;
    assign w_m_small = w_swap ? w_ma : w_mb;
    assign w_diff    = w_e_big - w_e_small;
    assign w_shamt   = (w_diff > 8'd26) ? 5'd26 : w_diff[4:0];

    // NORM: renormalise, then apply the zero / overflow / special overrides
    logic [4:0]        w_lzc;
    logic signed [9:0] w_res_exp;
    logic [22:0]       w_res_frac;
    logic [31:0]       w_result;

    fp_lzc24 u_lzc (
        .i_data  (r_sum[23:0]),
        .o_count (w_lzc)
    );

    always_comb begin
        w_res_exp  = $signed({2'b00, r_exp}) - $signed({5'd0, w_lzc});
        w_res_frac = 23'(r_sum[23:0] << w_lzc);
        if (r_sum[24]) begin
            w_res_exp  = $signed({2'b00, r_exp}) + 10'sd1;
            w_res_frac = r_sum[23:1];
        end
        if (r_special)
            w_result = r_special_val;
        else if (r_sum == 25'd0)
            w_result = {r_sa & r_sb, 31'd0};
        else if (w_res_exp <= 10'sd0)
            w_result = {r_sa, 31'd0};
        else if (w_res_exp >= 10'sd255)
            w_result = {r_sa, 8'hFF, 23'd0};
        else
            w_result = {r_sa, w_res_exp[7:0], w_res_frac};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_acc         <= 32'd0;
            r_cnt         <= '0;
            r_a_raw       <= 32'd0;
            r_b_raw       <= 32'd0;
            r_last        <= 1'b0;
            r_sa          <= 1'b0;
            r_sb          <= 1'b0;
            r_exp         <= 8'd0;
            r_ma          <= 24'd0;
            r_mb          <= 24'd0;
            r_sum         <= 25'd0;
            r_special     <= 1'b0;
            r_special_val <= 32'd0;
            r_acc_out     <= 32'd0;
            r_term_count  <= '0;
            r_out_valid   <= 1'b0;
            r_in_ready    <= 1'b1;
            r_busy        <= 1'b0;
        end else if (clear) begin
            r_state     <= ST_IDLE;
            r_acc       <= 32'd0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a_raw    <= bus.in_data;
                        r_b_raw    <= r_acc;
                        r_last     <= bus.in_last;
                        r_cnt      <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    r_sa      <= w_swap ? r_b_raw[FP_SIGN_BIT] : r_a_raw[FP_SIGN_BIT];
                    r_sb      <= w_swap ? r_a_raw[FP_SIGN_BIT] : r_b_raw[FP_SIGN_BIT];
                    r_exp     <= w_e_big;
                    r_ma      <= w_m_big;
                    r_mb      <= w_m_small >> w_shamt;
                    r_special <= w_a_nan | w_b_nan | w_a_inf | w_b_inf;
                    if (w_a_nan || w_b_nan ||
                        (w_a_inf && w_b_inf && (r_a_raw[FP_SIGN_BIT] != r_b_raw[FP_SIGN_BIT])))
                        r_special_val <= FP_QNAN;
                    else if (w_a_inf)
                        r_special_val <= r_a_raw;
                    else
                        r_special_val <= r_b_raw;
                    r_state <= ST_ADD;
                end
                ST_ADD: begin
                    r_sum   <= (r_sa == r_sb) ? ({1'b0, r_ma} + {1'b0, r_mb})
                                              : ({1'b0, r_ma} - {1'b0, r_mb});
                    r_state <= ST_NORM;
                end
                ST_NORM: begin
                    r_acc <= w_result;
                    if (r_last) begin
                        r_acc_out    <= w_result;
                        r_term_count <= r_cnt;
                        r_out_valid  <= 1'b1;
                        r_acc        <= 32'd0;
                        r_cnt        <= '0;
                    end
                    r_in_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.acc_out    = r_acc_out;
    assign bus.out_valid  = r_out_valid;
    assign bus.term_count = r_term_count;
    assign busy           = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_float_accumulator.sv
// ============================================================================
// Module  : tb_float_accumulator
// Brief   : Directed vector-table bench for float_accumulator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_float_accumulator;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic busy;

    float_accumulator_if #(.CNT_W(16)) bus ();

    float_accumulator #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          n;
        logic [31:0] t0;
        logic [31:0] t1;
        logic [31:0] t2;
        logic [31:0] exp_sum;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one term and hold it until the cycle in_ready is high.
    task automatic send(input logic [31:0] d, input logic last);
        int g;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        g = 0;
        while (!bus.in_ready && g < 20) begin
            tick();
            g++;
        end
        if (!bus.in_ready) check("in_ready timeout", 32'd0, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_out(output logic found);
        int g;
        g = 0;
        while (!bus.out_valid && g < 12) begin
            tick();
            g++;
        end
        found = bus.out_valid;
        if (!found) check("out_valid timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_batch(input string name, input logic [31:0] sum, input int cnt);
        logic found;
        wait_out(found);
        if (found) begin
            check({name, " sum"}, bus.acc_out, sum);
            check({name, " count"}, 32'(bus.term_count), 32'(cnt));
        end
        tick();
    endtask

    initial begin
        vecs[0]  = '{3, 32'h4040_0000, 32'h4040_0000, 32'h3FC0_0000, 32'h40F0_0000};
        vecs[1]  = '{2, 32'h4040_0000, 32'hC040_0000, 32'h0,         32'h0000_0000};
        vecs[2]  = '{1, 32'h4000_0000, 32'h0,         32'h0,         32'h4000_0000};
        vecs[3]  = '{2, 32'h4B80_0000, 32'h3F80_0000, 32'h0,         32'h4B80_0000};
        vecs[4]  = '{2, 32'h0000_0001, 32'h3F80_0000, 32'h0,         32'h3F80_0000};
        vecs[5]  = '{2, 32'h7F80_0000, 32'hFF80_0000, 32'h0,         32'h7FC0_0000};
        vecs[6]  = '{2, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h0,         32'h7F80_0000};
        vecs[7]  = '{2, 32'h7F80_0001, 32'h3F80_0000, 32'h0,         32'h7FC0_0000};
        vecs[8]  = '{2, 32'h3F80_0000, 32'hBF00_0000, 32'h0,         32'h3F00_0000};
        vecs[9]  = '{2, 32'h80C0_0000, 32'h0080_0000, 32'h0,         32'h8000_0000};
        vecs[10] = '{2, 32'hBFC0_0000, 32'h3E80_0000, 32'h0,         32'hBFA0_0000};

        rst = 1'b1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst acc_out", bus.acc_out, 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst term_count", 32'(bus.term_count), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        tick();

        // in_ready stays low for exactly the three working cycles
        send(32'h3F80_0000, 1'b0);
        check("busy T+1", 32'(busy), 32'd1);
        check("in_ready T+1", 32'(bus.in_ready), 32'd0);
        tick();
        check("in_ready T+2", 32'(bus.in_ready), 32'd0);
        tick();
        check("in_ready T+3", 32'(bus.in_ready), 32'd0);
        tick();
        check("in_ready T+4", 32'(bus.in_ready), 32'd1);
        send(32'h3F80_0000, 1'b1);
        expect_batch("one plus one", 32'h4000_0000, 2);
        check("out_valid single pulse", 32'(bus.out_valid), 32'd0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].n == 1) begin
                send(vecs[i].t0, 1'b1);
            end else if (vecs[i].n == 2) begin
                send(vecs[i].t0, 1'b0);
                send(vecs[i].t1, 1'b1);
            end else begin
                send(vecs[i].t0, 1'b0);
                send(vecs[i].t1, 1'b0);
                send(vecs[i].t2, 1'b1);
            end
            expect_batch($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].n);
        end

        // clear while the term is in ALIGN
        send(32'h4040_0000, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear busy", 32'(busy), 32'd0);
        check("clear in_ready", 32'(bus.in_ready), 32'd1);
        check("clear keeps acc_out", bus.acc_out, vecs[NV-1].exp_sum);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("clear no out_valid %0d", k), 32'(bus.out_valid), 32'd0);
            tick();
        end
        send(32'h3F80_0000, 1'b1);
        expect_batch("after clear", 32'h3F80_0000, 1);

        // reset while the term is in ADD
        send(32'h3F80_0000, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check("midrst acc_out", bus.acc_out, 32'd0);
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst term_count", 32'(bus.term_count), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        tick();
        send(32'h3F80_0000, 1'b1);
        expect_batch("after midrst", 32'h3F80_0000, 1);

        // in_valid held high for 8 edges: only two terms may enter
        begin
            int accepted;
            accepted = 0;
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h3F80_0000;
            bus.in_last  = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (bus.in_ready) accepted++;
                tick();
            end
            bus.in_valid = 1'b0;
            check("held valid accepts", 32'(accepted), 32'd2);
            check("held valid idle", 32'(busy), 32'd0);
        end
        send(32'h3F80_0000, 1'b1);
        expect_batch("held valid batch", 32'h4040_0000, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
